ll_window_acc: RTL and testbench

// Consumer side of the line-length comparison unit: accepts the per-sample
// |din[i]-din[i-1]| stream with its data_valid strobe, keeps the last 2**WIN_LOG2

---
 rtl/ll_window_acc.sv | 176 +++++++++++++++++
 tb/tb_ll_window_acc.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ll_window_acc.sv
// -----------------------------------------------------------------------------
// ll_window_acc
// Line-length window accumulator. Accepts the per-sample |din[i]-din[i-1]|
// stream, keeps the last N = 2**WIN_LOG2 accepted samples in a circular
// buffer and maintains their running sum. The sum is compared against a
// programmable threshold to flag detection events.
//
// Ports
//   clk          in   single clock, all logic on posedge
//   rst          in   synchronous reset, active high (wins over din_valid)
//   din          in   input_width+2 bit signed sample; MSB set => clamped to 0
//   din_valid    in   sample accepted on this edge when high
//   thresh       in   unsigned detection threshold, sampled every cycle
//   dout         out  unsigned window sum (registered)
//   dout_valid   out  one-cycle pulse: dout updated for an accepted sample
//   window_full  out  high once N samples have been accepted since reset
//   detect       out  window sum strictly greater than thresh (window full)
//
// Optional feature macro: LL_DETECT_HOLD_EN
//   undefined : detect is a single-cycle pulse aligned with dout_valid
//   defined   : detect is stretched for HOLD_LEN further accepted samples,
//               reloaded by every new qualifying compare
// -----------------------------------------------------------------------------
module ll_window_acc #(
    parameter int input_width = 32,
    parameter int WIN_LOG2    = 4,
    parameter int HOLD_LEN    = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic signed [input_width+1:0]     din,
    input  logic                              din_valid,
    input  logic [input_width+1+WIN_LOG2:0]   thresh,
    output logic [input_width+1+WIN_LOG2:0]   dout,
    output logic                              dout_valid,
    output logic                              window_full,
    output logic                              detect
);

    localparam int DW = input_width + 2;
    localparam int SW = DW + WIN_LOG2;
    localparam int N  = 1 << WIN_LOG2;
    localparam int CW = WIN_LOG2 + 1;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

    logic [DW-1:0]       win_buf_q [N];
    logic [WIN_LOG2-1:0] wr_ptr_q;
    logic [WIN_LOG2-1:0] wr_ptr_d;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    state_e              state_q;
    state_e              state_d;
    logic [SW-1:0]       sum_q;
    logic [SW-1:0]       sum_d;
    logic                dout_valid_q;
    logic                window_full_q;
    logic                detect_q;
    logic                detect_d;
    logic [DW-1:0]       s_s;
    logic [DW-1:0]       old_s;
    logic                hit_s;

`ifdef LL_DETECT_HOLD_EN
    localparam int HCW = (HOLD_LEN < 1) ? 1 : $clog2(HOLD_LEN + 1);
    logic [HCW-1:0]      hold_q;
    logic [HCW-1:0]      hold_d;
`endif

    // Next-state computation for the window, fill counter, FSM and detect.
    always_comb begin
        // Negative (MSB set) samples are illegal for an abs-difference: clamp to 0.
        if (din[DW-1] == 1'b1) begin
            s_s = {DW{1'b0}};
        end else begin
            s_s = din;
        end

        // Entry being overwritten is the sample exactly N acceptances old
        // (zero while filling, since the buffer is cleared by reset).
        old_s    = win_buf_q[wr_ptr_q];
        sum_d    = sum_q + {{WIN_LOG2{1'b0}}, s_s} - {{WIN_LOG2{1'b0}}, old_s};
        wr_ptr_d = wr_ptr_q + {{(WIN_LOG2-1){1'b0}}, 1'b1};

        if (cnt_q != CW'(N)) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            FILL: begin
                if (cnt_d == CW'(N)) begin
                    state_d = RUN;
                end else begin
                    state_d = FILL;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = FILL;
        endcase

        // Qualifying compare: only once the window is full, strictly greater.
        hit_s = (state_d == RUN) && (sum_d > thresh);

`ifdef LL_DETECT_HOLD_EN
        hold_d   = hold_q;
        detect_d = detect_q;
        if (din_valid) begin
            if (hit_s) begin
                hold_d   = HCW'(HOLD_LEN);
                detect_d = 1'b1;
            end else if (hold_q != {HCW{1'b0}}) begin
                hold_d   = hold_q - {{(HCW-1){1'b0}}, 1'b1};
                detect_d = 1'b1;
            end else begin
                hold_d   = {HCW{1'b0}};
                detect_d = 1'b0;
            end
        end else begin
            hold_d   = hold_q;
            detect_d = detect_q;
        end
`else
        if (din_valid) begin
            detect_d = hit_s;
        end else begin
            detect_d = 1'b0;
        end
`endif
    end

    // Window state, running sum and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                win_buf_q[i] <= {DW{1'b0}};
            end
            wr_ptr_q      <= {WIN_LOG2{1'b0}};
            cnt_q         <= {CW{1'b0}};
            state_q       <= FILL;
            sum_q         <= {SW{1'b0}};
            dout_valid_q  <= 1'b0;
            window_full_q <= 1'b0;
            detect_q      <= 1'b0;
`ifdef LL_DETECT_HOLD_EN
            hold_q        <= {HCW{1'b0}};
`endif
        end else begin
            if (din_valid) begin
                win_buf_q[wr_ptr_q] <= s_s;
                wr_ptr_q            <= wr_ptr_d;
                cnt_q               <= cnt_d;
                state_q             <= state_d;
                sum_q               <= sum_d;
                dout_valid_q        <= 1'b1;
                window_full_q       <= (state_d == RUN);
            end else begin
                dout_valid_q        <= 1'b0;
            end
            detect_q <= detect_d;
`ifdef LL_DETECT_HOLD_EN
            hold_q   <= hold_d;
`endif
        end
    end

    assign dout        = sum_q;
    assign dout_valid  = dout_valid_q;
    assign window_full = window_full_q;
    assign detect      = detect_q;

endmodule

// File: tb/tb_ll_window_acc.sv
// -----------------------------------------------------------------------------
// tb_ll_window_acc
// Directed, table-driven bench for ll_window_acc (base build, WIN_LOG2=4).
// Each table row is applied for one clock; the row's expected outputs are the
// values visible just after that clock edge. A few hand-written sequences
// follow for window wrap-around and output latency.
// -----------------------------------------------------------------------------
module tb_ll_window_acc;

    localparam int IW = 32;
    localparam int WL = 4;
    localparam int DW = IW + 2;
    localparam int SW = DW + WL;

    typedef struct {
        logic          rst;
        logic          vld;
        logic [DW-1:0] din;
        logic [SW-1:0] thr;
        logic [SW-1:0] e_dout;
        logic          e_dv;
        logic          e_full;
        logic          e_det;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [DW-1:0] din;
    logic          din_valid;
    logic [SW-1:0] thresh;
    logic [SW-1:0] dout;
    logic          dout_valid;
    logic          window_full;
    logic          detect;

    vec_t vt[$];
    int   total;
    int   bad;

    ll_window_acc #(
        .input_width(IW),
        .WIN_LOG2   (WL),
        .HOLD_LEN   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .thresh     (thresh),
        .dout       (dout),
        .dout_valid (dout_valid),
        .window_full(window_full),
        .detect     (detect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic v, input logic [DW-1:0] d,
                       input logic [SW-1:0] t, input logic [SW-1:0] ed,
                       input logic edv, input logic ef, input logic edt);
        vec_t x;
        x.rst = r; x.vld = v; x.din = d; x.thr = t;
        x.e_dout = ed; x.e_dv = edv; x.e_full = ef; x.e_det = edt;
        vt.push_back(x);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0d expected=%0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [SW-1:0] ed,
                             input logic edv, input logic ef, input logic edt);
        check("dout",        idx, 64'(dout),        64'(ed));
        check("dout_valid",  idx, 64'(dout_valid),  64'(edv));
        check("window_full", idx, 64'(window_full), 64'(ef));
        check("detect",      idx, 64'(detect),      64'(edt));
    endtask

    // Drive one row on the falling edge, sample just after the rising edge.
    task automatic step(input logic r, input logic v, input logic [DW-1:0] d,
                        input logic [SW-1:0] t);
        @(negedge clk);
        rst = r; din_valid = v; din = d; thresh = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] neg4;
        int            s;
        total = 0;
        bad   = 0;
        rst = 1'b1; din_valid = 1'b0; din = '0; thresh = '0;
        neg4 = 34'h3_FFFF_FFFC;

        // Reset state.
        add(1'b1, 1'b0, 34'd0, 38'd0, 38'd0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 34'd0, 38'd0, 38'd0, 1'b0, 1'b0, 1'b0);

        // 20 samples of 3, thresh 40: sum 3..48 then saturates at 48.
        // Detect requires a full window, so only samples 16..20 detect.
        for (int k = 1; k <= 20; k++) begin
            s = 3 * ((k < 16) ? k : 16);
            add(1'b0, 1'b1, 34'd3, 38'd40, 38'(s), 1'b1, (k >= 16), (k >= 16));
        end

        // Reset beats din_valid; then window slide: 16 x 1, then 100.
        add(1'b1, 1'b1, 34'd7, 38'd0, 38'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            add(1'b0, 1'b1, 34'd1, 38'd1000, 38'(k), 1'b1, (k == 16), 1'b0);
        end
        // sum == thresh must not detect; one above must.
        add(1'b0, 1'b1, 34'd100, 38'd115, 38'd115, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b1, 34'd1,   38'd114, 38'd115, 1'b1, 1'b1, 1'b1);

        // Idle cycles: everything holds, no detect even with thresh 0.
        add(1'b0, 1'b0, 34'd55, 38'd0, 38'd115, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 34'd55, 38'd0, 38'd115, 1'b0, 1'b1, 1'b0);

        // Negative input clamped to 0: oldest 1 leaves, nothing added.
        add(1'b0, 1'b1, neg4, 38'd1000, 38'd114, 1'b1, 1'b1, 1'b0);

        // Gaps do not age the window; no detect while filling.
        add(1'b1, 1'b0, 34'd0, 38'd0, 38'd0,  1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 34'd7, 38'd0, 38'd7,  1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 34'd7, 38'd0, 38'd7,  1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 34'd7, 38'd0, 38'd7,  1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 34'd7, 38'd0, 38'd14, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 34'd0, 38'd0, 38'd14, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 34'd7, 38'd0, 38'd21, 1'b1, 1'b0, 1'b0);

        // Mid-stream reset held 2 cycles, then 16 samples of 5.
        add(1'b1, 1'b1, 34'd9, 38'd0, 38'd0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 34'd9, 38'd0, 38'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            add(1'b0, 1'b1, 34'd5, 38'd79, 38'(5 * k), 1'b1, (k == 16), (k == 16));
        end

        foreach (vt[i]) begin
            step(vt[i].rst, vt[i].vld, vt[i].din, vt[i].thr);
            check_all(i, vt[i].e_dout, vt[i].e_dv, vt[i].e_full, vt[i].e_det);
        end

        // Wrap-around: window of 16 x 5 (sum 80) replaced one by one with 2s.
        for (int k = 1; k <= 17; k++) begin
            s = (k <= 16) ? (80 - 3 * k) : 32;
            step(1'b0, 1'b1, 34'd2, 38'd50);
            check_all(1000 + k, 38'(s), 1'b1, 1'b1, (s > 50));
        end

        // Latency: output does not change before the accepting edge.
        step(1'b0, 1'b0, 34'd0, 38'd50);
        check_all(2000, 38'd32, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        din_valid = 1'b1; din = 34'd40; thresh = 38'd50;
        #1;
        check_all(2001, 38'd32, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_all(2002, 38'd70, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all(2003, 38'd70, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
